// File: rtl/fib_regfile_datapath_pkg.sv
// Shared definitions for the fib_regfile_datapath execute slice: instruction
// codes, flag bit positions and operand helpers.
package fib_dp_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 16;

  // Register-form op; every other op value selects an immediate form.
  localparam logic [3:0] OP_REG = 4'b0000;

  // The same code space is used by ext (register form) and op (immediate form).
  typedef enum logic [3:0] {
    CODE_AND  = 4'b0001,
    CODE_OR   = 4'b0010,
    CODE_XOR  = 4'b0011,
    CODE_ADD  = 4'b0101,
    CODE_ADDU = 4'b0110,
    CODE_ADDC = 4'b0111,
    CODE_SUB  = 4'b1001,
    CODE_CMP  = 4'b1011,
    CODE_MOV  = 4'b1101
  } alu_code_e;

  localparam int FLAG_Z = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_L = 1;
  localparam int FLAG_N = 0;

  function automatic logic is_logical(input logic [3:0] code);
    return (code == CODE_AND) || (code == CODE_OR) || (code == CODE_XOR);
  endfunction

  function automatic logic [DATA_W-1:0] sign_ext8(input logic [7:0] imm);
    return {{(DATA_W-8){imm[7]}}, imm};
  endfunction

  function automatic logic [DATA_W-1:0] zero_ext8(input logic [7:0] imm);
    return {{(DATA_W-8){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/fib_regfile_datapath_hex_to_7seg.sv
// Hex digit to active-low seven-segment pattern, gfedcba order (bit 6 = g).
module hex_to_7seg (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (digit)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/fib_regfile_datapath.sv
// Single-cycle 16-bit execute datapath: register file, inline ALU and flags.
// Define SEG7_EN to add the 28-bit hex display output driven from rout.
module fib_regfile_datapath #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instr,
  input  logic              cin,
  output logic [4:0]        flags,
  output logic [DATA_W-1:0] rout
`ifdef SEG7_EN
  ,
  output logic [27:0]       display
`endif
);

  import fib_dp_pkg::*;

  logic [DATA_W-1:0] regs [NREGS];

  logic [3:0]        op;
  logic [3:0]        rd;
  logic [3:0]        ext;
  logic [3:0]        rs;
  logic [7:0]        imm8;
  logic [3:0]        code;
  logic              is_reg;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] src;

  assign op     = instr[15:12];
  assign rd     = instr[11:8];
  assign ext    = instr[7:4];
  assign rs     = instr[3:0];
  assign imm8   = instr[7:0];
  assign is_reg = (op == OP_REG);
  assign code   = is_reg ? ext : op;
  assign opa    = regs[rd];

  // Immediates: logical forms zero-extend, everything else sign-extends.
  always_comb begin
    src = '0;
    if (is_reg)
      src = regs[rs];
    else if (is_logical(code))
      src = zero_ext8(imm8);
    else
      src = sign_ext8(imm8);
  end

  logic [DATA_W:0]   sum_ext;
  logic [DATA_W:0]   diff_ext;
  logic              carry_in;
  logic [DATA_W-1:0] result;
  logic              do_write;
  logic [4:0]        next_flags;

  // ADDC takes its carry from the external cin, never from the C flag.
  assign carry_in = (code == CODE_ADDC) ? cin : 1'b0;
  assign sum_ext  = {1'b0, opa} + {1'b0, src} + {{DATA_W{1'b0}}, carry_in};
  assign diff_ext = {1'b0, opa} - {1'b0, src};

  always_comb begin
    result     = '0;
    do_write   = 1'b0;
    next_flags = flags;
    case (code)
      CODE_AND: begin
        result   = opa & src;
        do_write = 1'b1;
      end
      CODE_OR: begin
        result   = opa | src;
        do_write = 1'b1;
      end
      CODE_XOR: begin
        result   = opa ^ src;
        do_write = 1'b1;
      end
      CODE_ADD, CODE_ADDC: begin
        result             = sum_ext[DATA_W-1:0];
        do_write           = 1'b1;
        next_flags[FLAG_C] = sum_ext[DATA_W];
        next_flags[FLAG_F] = (opa[DATA_W-1] == src[DATA_W-1]) &&
                             (sum_ext[DATA_W-1] != opa[DATA_W-1]);
        next_flags[FLAG_Z] = (sum_ext[DATA_W-1:0] == '0);
        next_flags[FLAG_N] = sum_ext[DATA_W-1];
      end
      CODE_ADDU: begin
        result             = sum_ext[DATA_W-1:0];
        do_write           = 1'b1;
        next_flags[FLAG_C] = sum_ext[DATA_W];
      end
      CODE_SUB: begin
        result             = diff_ext[DATA_W-1:0];
        do_write           = 1'b1;
        next_flags[FLAG_C] = (opa < src);
        next_flags[FLAG_F] = (opa[DATA_W-1] != src[DATA_W-1]) &&
                             (diff_ext[DATA_W-1] != opa[DATA_W-1]);
        next_flags[FLAG_Z] = (diff_ext[DATA_W-1:0] == '0);
        next_flags[FLAG_N] = diff_ext[DATA_W-1];
      end
      CODE_CMP: begin
        next_flags[FLAG_Z] = (opa == src);
        next_flags[FLAG_L] = (opa < src);
        next_flags[FLAG_N] = ($signed(opa) < $signed(src));
      end
      CODE_MOV: begin
        result   = src;
        do_write = 1'b1;
      end
      default: begin
        result   = '0;
        do_write = 1'b0;
      end
    endcase
  end

  // Reset wins over the instruction presented in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      flags <= '0;
      rout  <= '0;
    end else begin
      flags <= next_flags;
      if (do_write) begin
        regs[rd] <= result;
        rout     <= result;
      end
    end
  end

`ifdef SEG7_EN
  hex_to_7seg u_dig3 (.digit(rout[15:12]), .seg(display[27:21]));
  hex_to_7seg u_dig2 (.digit(rout[11:8]),  .seg(display[20:14]));
  hex_to_7seg u_dig1 (.digit(rout[7:4]),   .seg(display[13:7]));
  hex_to_7seg u_dig0 (.digit(rout[3:0]),   .seg(display[6:0]));
`endif

endmodule

// File: tb/tb_fib_regfile_datapath.sv
// Directed scoreboard bench for fib_regfile_datapath; checks the display
// patterns too when built with SEG7_EN.
module tb_fib_regfile_datapath;

  logic        clk;
  logic        reset;
  logic [15:0] instr;
  logic        cin;
  logic [4:0]  flags;
  logic [15:0] rout;
`ifdef SEG7_EN
  logic [27:0] display;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] rout;
    logic [4:0]  flags;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_regs [16];
  logic [4:0]  m_flags;
  logic [15:0] m_rout;

  fib_regfile_datapath dut (
    .clk    (clk),
    .reset  (reset),
    .instr  (instr),
    .cin    (cin),
    .flags  (flags),
    .rout   (rout)
`ifdef SEG7_EN
    ,
    .display(display)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] enc_r(input logic [3:0] ext, input logic [3:0] rd,
                                        input logic [3:0] rs);
    return {4'b0000, rd, ext, rs};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [7:0] imm);
    return {op, rd, imm};
  endfunction

  // Reference model written with integer arithmetic and range tests.
  task automatic model_exec(input logic [15:0] ins, input logic c, input logic rst);
    logic [3:0]  op, rd, ext, rs, code;
    logic [7:0]  imm;
    logic [15:0] a, b, res;
    int          ua, ub, sa, sb, s, ss, cy;
    logic        wr;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
      m_flags = 5'b00000;
      m_rout  = 16'h0000;
      return;
    end
    op = ins[15:12]; rd = ins[11:8]; ext = ins[7:4]; rs = ins[3:0]; imm = ins[7:0];
    code = (op == 4'd0) ? ext : op;
    a = m_regs[rd];
    if (op == 4'd0)                            b = m_regs[rs];
    else if (code >= 4'd1 && code <= 4'd3)     b = {8'h00, imm};
    else                                       b = {{8{imm[7]}}, imm};
    ua = int'({16'h0000, a});
    ub = int'({16'h0000, b});
    sa = int'($signed(a));
    sb = int'($signed(b));
    cy = (code == 4'd7) ? int'({31'd0, c}) : 0;
    wr = 1'b1;
    res = 16'h0000;
    s = 0;
    case (code)
      4'd1: res = a & b;
      4'd2: res = a | b;
      4'd3: res = a ^ b;
      4'd5, 4'd7: begin
        s = ua + ub + cy; ss = sa + sb + cy; res = s[15:0];
        m_flags[3] = (s > 65535);
        m_flags[2] = (ss > 32767) || (ss < -32768);
        m_flags[4] = (res == 16'h0000);
        m_flags[0] = res[15];
      end
      4'd6: begin
        s = ua + ub; res = s[15:0];
        m_flags[3] = (s > 65535);
      end
      4'd9: begin
        s = ua - ub; ss = sa - sb; res = s[15:0];
        m_flags[3] = (ua < ub);
        m_flags[2] = (ss > 32767) || (ss < -32768);
        m_flags[4] = (res == 16'h0000);
        m_flags[0] = res[15];
      end
      4'd11: begin
        wr = 1'b0;
        m_flags[4] = (ua == ub);
        m_flags[1] = (ua < ub);
        m_flags[0] = (sa < sb);
      end
      4'd13: res = b;
      default: wr = 1'b0;
    endcase
    if (wr) begin
      m_regs[rd] = res;
      m_rout     = res;
    end
  endtask

  task automatic check_output();
    exp_t e;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_empty observed 0 entries expected 1");
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      assert (rout === e.rout) else begin
        errors++;
        $error("[TB] FAIL %s rout observed %h expected %h", e.tag, rout, e.rout);
      end
      checks++;
      assert (flags === e.flags) else begin
        errors++;
        $error("[TB] FAIL %s flags observed %b expected %b", e.tag, flags, e.flags);
      end
    end
  endtask

  task automatic check_const(input string tag, input logic [27:0] observed,
                             input logic [27:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input string tag, input logic [15:0] ins,
                                input logic c = 1'b0, input logic rst = 1'b0);
    exp_t e;
    @(negedge clk);
    instr = ins;
    cin   = c;
    reset = rst;
    model_exec(ins, c, rst);
    e.tag = tag; e.rout = m_rout; e.flags = m_flags;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_output();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    instr = 16'h0000;
    cin   = 1'b0;
    m_flags = 5'b00000;
    m_rout  = 16'h0000;

    $display("[TB] reset and idle");
    apply_stimulus("reset", 16'h0000, 1'b0, 1'b1);
    check_const("reset_rout", {12'd0, rout}, 28'd0);
    check_const("reset_flags", {23'd0, flags}, 28'd0);
    apply_stimulus("idle_undef_r", 16'h0000);
    for (int k = 0; k < 16; k++)
      apply_stimulus("probe_mov", enc_r(4'b1101, 4'(k), 4'(k)));

    $display("[TB] fibonacci");
    apply_stimulus("fib_addi_r0", enc_i(4'b0101, 4'd0, 8'd1));
    apply_stimulus("fib_addi_r1", enc_i(4'b0101, 4'd1, 8'd1));
    apply_stimulus("fib_add_r1", enc_r(4'b0101, 4'd1, 4'd0));
    for (int k = 2; k < 15; k++) begin
      apply_stimulus("fib_mov", enc_r(4'b1101, 4'(k), 4'(k - 1)));
      apply_stimulus("fib_add", enc_r(4'b0101, 4'(k), 4'(k - 2)));
    end
    apply_stimulus("fib_mov_r15", enc_r(4'b1101, 4'd15, 4'd14));
    check_const("fib_final_rout", {12'd0, rout}, 28'h00003DB);
    check_const("fib_final_flags", {23'd0, flags}, 28'd0);
    apply_stimulus("undef_op4", enc_i(4'b0100, 4'd15, 8'h12));
    check_const("undef_hold_rout", {12'd0, rout}, 28'h00003DB);

    $display("[TB] carry");
    apply_stimulus("movi_m1", enc_i(4'b1101, 4'd4, 8'hFF));
    apply_stimulus("addi_wrap", enc_i(4'b0101, 4'd4, 8'h01));
    check_const("wrap_rout", {12'd0, rout}, 28'd0);
    check_const("wrap_flags", {23'd0, flags}, 28'b11000);
    apply_stimulus("movi_r5", enc_i(4'b1101, 4'd5, 8'h00));
    apply_stimulus("movi_r6", enc_i(4'b1101, 4'd6, 8'h00));
    apply_stimulus("addc_cin", enc_r(4'b0111, 4'd5, 4'd6), 1'b1);
    check_const("addc_rout", {12'd0, rout}, 28'd1);
    apply_stimulus("movi_r9", enc_i(4'b1101, 4'd9, 8'hFF));
    apply_stimulus("addui_carry", enc_i(4'b0110, 4'd9, 8'h01));
    apply_stimulus("sub_self", enc_r(4'b1001, 4'd3, 4'd3));
    apply_stimulus("movi_r10", enc_i(4'b1101, 4'd10, 8'h00));
    apply_stimulus("xori_zext", enc_i(4'b0011, 4'd10, 8'h80));
    check_const("xori_zext_rout", {12'd0, rout}, 28'h0000080);
    apply_stimulus("addi_sext", enc_i(4'b0101, 4'd10, 8'h80));
    apply_stimulus("andi", enc_i(4'b0001, 4'd1, 8'h0F));
    apply_stimulus("or_reg", enc_r(4'b0010, 4'd1, 4'd2));

    $display("[TB] overflow and compare");
    apply_stimulus("movi_r7", enc_i(4'b1101, 4'd7, 8'h40));
    for (int k = 0; k < 9; k++)
      apply_stimulus("double_r7", enc_r(4'b0101, 4'd7, 4'd7));
    apply_stimulus("subi_r7", enc_i(4'b1001, 4'd7, 8'h01));
    check_const("r7_7fff", {12'd0, rout}, 28'h0007FFF);
    apply_stimulus("addi_ovf", enc_i(4'b0101, 4'd7, 8'h01));
    check_const("ovf_rout", {12'd0, rout}, 28'h0008000);
    check_const("ovf_fn", {26'd0, flags[2], flags[0]}, 28'b11);
    apply_stimulus("cmpi_neg", enc_i(4'b1011, 4'd7, 8'h00));
    check_const("cmpi_rout_held", {12'd0, rout}, 28'h0008000);
    check_const("cmpi_zln", {25'd0, flags[4], flags[1], flags[0]}, 28'b001);
    apply_stimulus("cmp_reg", enc_r(4'b1011, 4'd0, 4'd7));
    apply_stimulus("xor_reg", enc_r(4'b0011, 4'd8, 4'd7));

    $display("[TB] reset mid-run");
    apply_stimulus("rst_mid", enc_r(4'b0101, 4'd1, 4'd2), 1'b0, 1'b1);
    check_const("rst_mid_rout", {12'd0, rout}, 28'd0);
    check_const("rst_mid_flags", {23'd0, flags}, 28'd0);
    apply_stimulus("post_rst_r1", enc_i(4'b0101, 4'd1, 8'h10));
    apply_stimulus("post_rst_r7", enc_i(4'b0101, 4'd7, 8'h10));
    apply_stimulus("post_rst_r15", enc_i(4'b0101, 4'd15, 8'h10));

    $display("[TB] display value");
    apply_stimulus("movi_r2", enc_i(4'b1101, 4'd2, 8'h0A));
    for (int k = 0; k < 8; k++)
      apply_stimulus("shift_r2", enc_r(4'b0101, 4'd2, 4'd2));
    apply_stimulus("ori_r2", enc_i(4'b0010, 4'd2, 8'hBF));
    check_const("rout_0abf", {12'd0, rout}, 28'h0000ABF);
`ifdef SEG7_EN
    check_const("display_0abf", display,
                {7'b1000000, 7'b0001000, 7'b0000011, 7'b0001110});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fib_regfile_datapath.md
Name: fib_regfile_datapath

Overview:
- Single-cycle 16-bit execute datapath: 16x16 register file, ALU and 5-bit flag register, driven by one CR16-style instruction word per clock.
- Sits under a test/sequencing FSM that supplies instructions and an external carry-in.
- Exposes the last written result for a 4-digit hex 7-segment display.

Parameters:
- DATA_W, 16: register and ALU width. The instruction format fixes this at 16.
- NREGS, 16: register count. Addressed by the 4-bit fields.

Ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high.
- instr, input, 16: instruction executed at the next rising edge.
- cin, input, 1: carry-in consumed by ADDC/ADDCI.
- flags, output, 5: registered flags, {Z, C, F, L, N} in bits [4:0]; bit 3 is carry.
- rout, output, 16: registered copy of the last value written to the register file.
- display, output, 28: present only with SEG7_EN; digits [27:21]..[6:0] show rout[15:12]..rout[3:0].

Behaviour:
- Field layout: op = instr[15:12], rd = instr[11:8], ext = instr[7:4], rs = instr[3:0], imm8 = instr[7:0].
- Register form (op=0000), by ext:
  - AND 0001, OR 0010, XOR 0011
  - ADD 0101, ADDU 0110, ADDC 0111
  - SUB 1001, CMP 1011, MOV 1101
- Register-form semantics: rd <= rd OP rs. MOV gives rd <= rs. CMP writes nothing.
- Immediate forms use op equal to the same codes: ANDI, ORI, XORI, ADDI, ADDUI, ADDCI, SUBI, CMPI, MOVI.
  - Arithmetic forms and MOVI sign-extend imm8.
  - Logical forms zero-extend imm8.
- Example: 0101_0000_0000_0001 gives r0 <= r0 + 1.
- Timing: one instruction per cycle. Operands are read combinationally; rd, rout and flags update at the same edge. Latency is 1 cycle.
- Reset (synchronous):
  - All registers, flags and rout clear to 0.
  - reset overrides instr in the same cycle.
  - Asserting reset mid-sequence discards the pending instruction.
- Flag rules:
  - ADD/ADDC/ADDI/ADDCI: C = carry-out of the 17-bit sum; F = signed overflow; Z = result==0; N = result[15].
  - ADDU/ADDUI: C only; other flags held.
  - SUB/SUBI: C = borrow (rd < src unsigned); F = signed overflow; Z; N.
  - CMP/CMPI: Z = (rd==src); L = rd<src unsigned; N = rd<src signed. C and F are held.
  - Logical ops and MOV: result written, flags held.
- ADDC adds cin as the LSB carry, not the internal C flag. The sequencer feeds C back externally.
- Wrap-around: results are modulo 2^16. Carry/overflow is reported only through flags.
- Self-writes (rd==rs) use the pre-edge values.
- Undefined op/ext: no register write; rout and flags hold.
- rout holds its value across CMP and across undefined instructions.

Optional Feature:
- Macro: SEG7_EN.
- Defined:
  - Four hex-to-7-seg decoders drive display from rout, combinationally.
  - Active-low segments in gfedcba order, bit 6 = g.
  - Glyphs 0-9 and A,b,C,d,E,F. Example: 0 -> 1000000, F -> 0001110.
- Undefined: the display port and the decoders are absent; all other behaviour is identical.

Decomposition:
- Package fib_dp_pkg holds:
  - op and ext code constants;
  - flag bit indices (Z=4, C=3, F=2, L=1, N=0);
  - DATA_W.
- Sub-module hex_to_7seg: 4-bit in, 7-bit out, pure combinational, instantiated 4x under SEG7_EN.
- The ALU stays inline.

Test Plan:
- Reset, then idle: reset=1 for 1 cycle -> flags=00000, rout=0000, all registers read 0 through MOV probes.
- Fibonacci sequence:
  - ADDI r0,1; ADDI r1,1; ADD r1+=r0; MOV r2<-r1; ADD r2+=r0; MOV r3<-r2; ADD r3+=r1, and so on through r15.
  - rout follows 1,1,2,2,3,3,5,5,8,...
  - Final rout=0x03DB (987); all flags 0 throughout.
- Carry:
  - MOVI r4,-1 (0xFFFF); ADDI r4,1 -> rout=0000, C=1, Z=1.
  - Then ADDC r5(=0)+r6(=0) with cin=1 -> rout=0001.
- Overflow/compare:
  - r7=0x7FFF; ADDI r7,1 -> rout=0x8000, F=1, N=1.
  - CMPI r7,0 -> L=0, N=1 (0x8000 is negative signed), Z=0; rout unchanged.
- Reset mid-run: assert reset with an ADD pending -> no write, registers/flags/rout = 0 after the edge.
- SEG7_EN: rout=0x0ABF -> display digit patterns 1000000, 0001000, 0000011, 0001110.
